// File: rtl/enc_rr_arbiter.sv
// enc_rr_arbiter
//   Round-robin arbiter sharing one downstream unit among N_REQ (=8)
//   requesters. The winner is reported as a one-hot grant and as a 3-bit
//   index built with the same OR-mapping as the 8x3 encoder. An optional hold
//   limit (MAX_HOLD, 0 = unlimited) forces rotation when others are waiting.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req       in   [7:0] request vector, bit i = requester i
//   gnt       out  [7:0] one-hot grant (registered)
//   gnt_idx   out  [2:0] binary index of the granted requester, 0 when idle
//   gnt_valid out        high whenever gnt is non-zero
//   hold_cnt  out  [7:0] 0-based length of the current tenure, saturating
module enc_rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_idx,
  output logic             gnt_valid,
  output logic [7:0]       hold_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic       HOLD_LIMITED = (MAX_HOLD != 0);
  // Last allowed hold_cnt value of a tenure; unused when unlimited.
  localparam logic [7:0] HOLD_LAST    = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD - 1);

  // 8x3 encoder: each index bit is the OR of the one-hot positions having it set.
  function automatic logic [2:0] enc8x3(input logic [7:0] oh);
    logic [2:0] idx;
    idx[0] = oh[1] | oh[3] | oh[5] | oh[7];
    idx[1] = oh[2] | oh[3] | oh[6] | oh[7];
    idx[2] = oh[4] | oh[5] | oh[6] | oh[7];
    return idx;
  endfunction

  // First set bit of r searching start, start+1, ... start+7 (mod 8).
  // Result is {found, index}; iterating from the far end lets the nearest hit win.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t     state_r;
  logic [7:0] gnt_r;
  logic [2:0] gnt_idx_r;
  logic       gnt_valid_r;
  logic [7:0] hold_cnt_r;
  logic [2:0] ptr_r;

  logic [3:0] idle_pick_s;
  logic [3:0] other_pick_s;
  logic       owner_req_s;
  logic       at_limit_s;
  logic       start_s;
  logic [2:0] start_idx_s;
  state_t     nxt_state_s;
  logic [7:0] nxt_gnt_s;
  logic [7:0] nxt_hold_s;
  logic [2:0] nxt_ptr_s;

  // Candidate winners: from the rotation pointer when idle, and from the
  // position after the current owner (owner masked) when busy.
  always_comb begin
    idle_pick_s  = rr_pick(req, ptr_r);
    other_pick_s = rr_pick(req & ~gnt_r, gnt_idx_r + 3'd1);
    owner_req_s  = |(req & gnt_r);
    at_limit_s   = HOLD_LIMITED && (hold_cnt_r == HOLD_LAST);
  end

  // Next-state decision for the arbitration FSM.
  always_comb begin
    nxt_state_s = state_r;
    nxt_gnt_s   = gnt_r;
    nxt_hold_s  = hold_cnt_r;
    nxt_ptr_s   = ptr_r;
    start_s     = 1'b0;
    start_idx_s = 3'd0;
    case (state_r)
      IDLE: begin
        if (idle_pick_s[3]) begin
          start_s     = 1'b1;
          start_idx_s = idle_pick_s[2:0];
        end else begin
          nxt_gnt_s  = 8'h00;
          nxt_hold_s = 8'h00;
        end
      end
      BUSY: begin
        if (!owner_req_s || at_limit_s) begin
          if (other_pick_s[3]) begin
            start_s     = 1'b1;
            start_idx_s = other_pick_s[2:0];
          end else if (!owner_req_s) begin
            nxt_state_s = IDLE;
            nxt_gnt_s   = 8'h00;
            nxt_hold_s  = 8'h00;
          end else begin
            // Limit reached but nobody else wants the unit: owner keeps it.
            nxt_hold_s = 8'h00;
          end
        end else if (hold_cnt_r != 8'hFF) begin
          nxt_hold_s = hold_cnt_r + 8'd1;
        end else begin
          nxt_hold_s = hold_cnt_r;
        end
      end
      default: begin
        nxt_state_s = IDLE;
        nxt_gnt_s   = 8'h00;
        nxt_hold_s  = 8'h00;
      end
    endcase
    if (start_s) begin
      nxt_state_s = BUSY;
      nxt_gnt_s   = 8'h01 << start_idx_s;
      nxt_hold_s  = 8'h00;
      nxt_ptr_s   = start_idx_s + 3'd1;
    end else begin
      nxt_ptr_s = nxt_ptr_s;
    end
  end

  // Arbitration state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= 8'h00;
      gnt_idx_r   <= 3'd0;
      gnt_valid_r <= 1'b0;
      hold_cnt_r  <= 8'h00;
      ptr_r       <= 3'd0;
    end else begin
      state_r     <= nxt_state_s;
      gnt_r       <= nxt_gnt_s;
      gnt_idx_r   <= enc8x3(nxt_gnt_s);
      gnt_valid_r <= |nxt_gnt_s;
      hold_cnt_r  <= nxt_hold_s;
      ptr_r       <= nxt_ptr_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign hold_cnt  = hold_cnt_r;

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Directed bench for enc_rr_arbiter: one instance with unlimited hold and one
// with MAX_HOLD=4, both fed the same request vector. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_enc_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;

  logic [7:0] gnt0, gnt4;
  logic [2:0] idx0, idx4;
  logic       vld0, vld4;
  logic [7:0] hold0, hold4;

  int total = 0;
  int bad   = 0;

  enc_rr_arbiter #(.N_REQ(8), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0), .hold_cnt(hold0)
  );

  enc_rr_arbiter #(.N_REQ(8), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4), .hold_cnt(hold4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: position of the set bit, 0 when none.
  function automatic logic [2:0] ref_enc(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) r = 3'(i);
    end
    return r;
  endfunction

  initial begin
    logic [2:0] e_idx;
    logic [7:0] flip;
    logic [7:0] req_cur;
    int wait0 [8];
    int wait4 [8];
    int max_wait0;
    int max_wait4;

    // ---- reset with all requests high ----
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_gnt",   gnt0, 8'h00);
    check("rst_idx",   idx0, 3'd0);
    check("rst_valid", vld0, 1'b0);
    check("rst_hold",  hold0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_gnt",   gnt0, 8'h01);
    check("rel_idx",   idx0, 3'd0);
    check("rel_valid", vld0, 1'b1);
    // asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt",   gnt0, 8'h00);
    check("async_valid", vld0, 1'b0);
    check("async_gnt4",  gnt4, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h00;

    // ---- single requester 4 for three cycles ----
    @(negedge clk);
    check("idle_valid", vld0, 1'b0);
    req = 8'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("r4_gnt",  gnt0, 8'h10);
      check("r4_idx",  idx0, 3'd4);
      check("r4_hold", hold0, 8'(k));
    end
    req = 8'h00;
    @(negedge clk);
    check("r4_drop_valid", vld0, 1'b0);
    check("r4_drop_gnt",   gnt0, 8'h00);

    // ---- round robin 0..7,0 with each owner releasing after one cycle ----
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int s = 0; s < 9; s++) begin
      @(negedge clk);
      e_idx = 3'(s % 8);
      check("rr_idx",   idx0, e_idx);
      check("rr_gnt",   gnt0, 8'h01 << e_idx);
      check("rr_valid", vld0, 1'b1);
      check("rr_idx4",  idx4, e_idx);
      req = 8'hFF & ~(8'h01 << e_idx);
    end
    req = 8'h00;
    @(negedge clk);
    check("rr_end_valid", vld0, 1'b0);

    // ---- hold limit with requesters 1 and 7 both held ----
    req = 8'h82;
    for (int s = 0; s < 9; s++) begin
      @(negedge clk);
      check("lim_idx4",  idx4, ((s / 4) % 2 == 1) ? 3'd7 : 3'd1);
      check("lim_hold4", hold4, 8'(s % 4));
      check("nolim_idx0",  idx0, 3'd1);
      check("nolim_hold0", hold0, 8'(s));
    end
    req = 8'h00;
    @(negedge clk);
    check("lim_end_valid4", vld4, 1'b0);

    // ---- hold limit with a lone requester 5 ----
    req = 8'h20;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      check("lone_gnt4",  gnt4, 8'h20);
      check("lone_hold4", hold4, 8'(s % 4));
      check("lone_vld4",  vld4, 1'b1);
    end
    req = 8'h00;
    @(negedge clk);

    // ---- release and new requests in the same cycle ----
    req = 8'h08;
    @(negedge clk);
    check("sim_own3", idx0, 3'd3);
    req = 8'h44;
    @(negedge clk);
    check("sim_next6", idx0, 3'd6);
    check("sim_gnt6",  gnt0, 8'h40);
    check("sim_hold6", hold0, 8'h00);
    req = 8'h04;
    @(negedge clk);
    check("sim_next2", idx0, 3'd2);
    check("sim_vld2",  vld0, 1'b1);
    req = 8'h00;
    @(negedge clk);

    // ---- hold counter saturation ----
    req = 8'h01;
    repeat (300) @(negedge clk);
    check("sat_hold0", hold0, 8'hFF);
    check("sat_gnt0",  gnt0, 8'h01);
    check("sat_hold4", hold4, 8'd3);
    req = 8'h00;
    @(negedge clk);

    // ---- random requests: invariants and starvation bound ----
    for (int i = 0; i < 8; i++) begin
      wait0[i] = 0;
      wait4[i] = 0;
    end
    max_wait0 = 0;
    max_wait4 = 0;
    req_cur   = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      check("rnd_onehot0", ($countones(gnt0) <= 1), 1'b1);
      check("rnd_enc0",    idx0, ref_enc(gnt0));
      check("rnd_vld0",    vld0, |gnt0);
      check("rnd_onehot4", ($countones(gnt4) <= 1), 1'b1);
      check("rnd_enc4",    idx4, ref_enc(gnt4));
      check("rnd_vld4",    vld4, |gnt4);
      // req_cur was sampled at the edge these outputs came from
      for (int i = 0; i < 8; i++) begin
        if (!req_cur[i] || gnt0[i]) wait0[i] = 0;
        else if (vld0 && hold0 == 8'h00) wait0[i]++;
        if (!req_cur[i] || gnt4[i]) wait4[i] = 0;
        else if (vld4 && hold4 == 8'h00) wait4[i]++;
        if (wait0[i] > max_wait0) max_wait0 = wait0[i];
        if (wait4[i] > max_wait4) max_wait4 = wait4[i];
      end
      flip    = 8'($urandom & $urandom);
      req_cur = req_cur ^ flip;
      req     = req_cur;
    end
    check("starve0", (max_wait0 < 8), 1'b1);
    check("starve4", (max_wait4 < 8), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
